// File: rtl/reg_dump_reader_pkg.sv
// Shared constants and FSM state type for the register dump reader.
package reg_dump_reader_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned DATA_W   = 128;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks all architectural registers once per start request and
// streams {index, data} entries over a valid/ready handshake.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [IDX_W-1:0]  rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [IDX_W-1:0]  dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      index_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    idx_d   = idx_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          index_d = '0;
        end
      end
      READ: begin
        idx_d   = index_q;
        data_d  = rf_data;
        state_d = SEND;
      end
      SEND: begin
        if (dump_ready) begin
          // Index returns to 0 so rf_addr reads 0 once the dump ends.
          if (index_q == LAST_IDX) begin
            state_d = DONE;
            index_d = '0;
          end else begin
            state_d = READ;
            index_d = index_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rf_addr    = index_q;
  assign dump_valid = (state_q == SEND);
  assign dump_idx   = idx_q;
  assign dump_data  = data_q;
  assign busy       = (state_q == READ) || (state_q == SEND);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader with a queue scoreboard.
module tb_reg_dump_reader;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [4:0]   rf_addr;
  logic [127:0] rf_data;
  logic         dump_valid;
  logic         dump_ready;
  logic [4:0]   dump_idx;
  logic [127:0] dump_data;
  logic         busy;
  logic         done;

  logic [127:0] rf [32];
  assign rf_data = rf[rf_addr];

  typedef struct {
    logic [4:0]   idx;
    logic [127:0] data;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int done_cnt = 0;

  bit           pend31 = 1'b0;
  bit           have_prev = 1'b0;
  logic [4:0]   prev_idx;
  logic [127:0] prev_data;

  reg_dump_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pend31    = 1'b0;
      have_prev = 1'b0;
    end else begin
      chk("done_after_31", done, pend31);
      if (done) done_cnt++;
      pend31 = 1'b0;
      if (dump_valid) begin
        if (have_prev) begin
          chk("stall_idx", dump_idx, prev_idx);
          chk("stall_data", dump_data, prev_data);
        end
        if (dump_ready) begin
          have_prev = 1'b0;
          if (q.size() == 0) begin
            chk("unexpected_entry", dump_idx, 5'h1f ^ dump_idx);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("entry_idx", dump_idx, e.idx);
            chk("entry_data", dump_data, e.data);
          end
          acc_cnt++;
          if (dump_idx == 5'd31) pend31 = 1'b1;
        end else begin
          have_prev = 1'b1;
          prev_idx  = dump_idx;
          prev_data = dump_data;
        end
      end else begin
        have_prev = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump();
    for (int i = 0; i < 32; i++) begin
      exp_t e;
      e.idx  = 5'(i);
      e.data = rf[i];
      q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    push_dump();
    cyc();
    start = 1'b0;
  endtask

  task automatic run_to_idx(input bit toggle, input logic [4:0] stop);
    bit hit = 1'b0;
    for (int n = 0; n < 200; n++) begin
      cyc();
      if (dump_valid && dump_idx == stop) begin
        dump_ready = 1'b0;
        hit = 1'b1;
        break;
      end
      dump_ready = toggle ? ~dump_ready : 1'b1;
    end
    chk("reached_idx", hit, 1'b1);
  endtask

  task automatic run_to_done(input bit toggle);
    bit hit = 1'b0;
    for (int n = 0; n < 300; n++) begin
      cyc();
      if (done) begin
        hit = 1'b1;
        break;
      end
      dump_ready = toggle ? ~dump_ready : 1'b1;
    end
    chk("reached_done", hit, 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, dump_valid, 1'b0);
    chk({tag, "_idx"}, dump_idx, 5'd0);
    chk({tag, "_data"}, dump_data, 128'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_addr"}, rf_addr, 5'd0);
  endtask

  initial begin
    int a0;
    int d0;
    rst = 1'b1;
    start = 1'b0;
    dump_ready = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 128'(i * 32'h0101);
    #1;
    chk_all_zero("rst_init");
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("idle_busy", busy, 1'b0);

    // basic dump, ready held high
    a0 = acc_cnt; d0 = done_cnt;
    dump_ready = 1'b1;
    pulse_start();
    chk("read_busy", busy, 1'b1);
    chk("read_valid", dump_valid, 1'b0);
    chk("read_addr", rf_addr, 5'd0);
    cyc();
    chk("first_valid", dump_valid, 1'b1);
    chk("first_idx", dump_idx, 5'd0);
    run_to_done(1'b0);
    chk("done_busy", busy, 1'b0);
    chk("done_valid", dump_valid, 1'b0);
    cyc();
    chk("post_addr", rf_addr, 5'd0);
    chk("basic_count", acc_cnt - a0, 32);
    chk("basic_dones", done_cnt - d0, 1);
    chk("basic_q", q.size(), 0);

    // ready toggling every cycle
    a0 = acc_cnt; d0 = done_cnt;
    dump_ready = 1'b0;
    pulse_start();
    run_to_done(1'b1);
    cyc();
    chk("toggle_count", acc_cnt - a0, 32);
    chk("toggle_dones", done_cnt - d0, 1);
    chk("toggle_q", q.size(), 0);

    // write to held entry while stalled
    dump_ready = 1'b1;
    pulse_start();
    run_to_idx(1'b0, 5'd5);
    cyc();
    rf[5] = 128'hDEAD;
    repeat (3) cyc();
    chk("held_data", dump_data, 128'h0505);
    run_to_done(1'b0);
    cyc();
    dump_ready = 1'b1;
    pulse_start();
    run_to_done(1'b0);
    cyc();
    chk("dead_q", q.size(), 0);

    // start while busy and in DONE is ignored
    a0 = acc_cnt; d0 = done_cnt;
    dump_ready = 1'b1;
    pulse_start();
    run_to_idx(1'b0, 5'd10);
    start = 1'b1;
    cyc();
    start = 1'b0;
    dump_ready = 1'b1;
    run_to_done(1'b0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("done_start_busy", busy, 1'b0);
    cyc();
    chk("done_start_idle", busy, 1'b0);
    chk("restart_count", acc_cnt - a0, 32);
    chk("restart_dones", done_cnt - d0, 1);
    chk("restart_q", q.size(), 0);

    // async reset mid-dump
    d0 = done_cnt;
    dump_ready = 1'b1;
    pulse_start();
    run_to_idx(1'b0, 5'd17);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    q.delete();
    repeat (3) cyc();
    rst = 1'b0;
    chk("rst_no_done", done_cnt - d0, 0);
    cyc();
    a0 = acc_cnt;
    dump_ready = 1'b1;
    pulse_start();
    cyc();
    chk("rst_restart_idx", dump_idx, 5'd0);
    chk("rst_restart_valid", dump_valid, 1'b1);
    run_to_done(1'b0);
    cyc();
    chk("rst_restart_count", acc_cnt - a0, 32);

    // long stall on the last entry
    dump_ready = 1'b1;
    pulse_start();
    run_to_idx(1'b0, 5'd31);
    for (int n = 0; n < 100; n++) begin
      cyc();
      chk("stall31_valid", dump_valid, 1'b1);
      chk("stall31_done", done, 1'b0);
    end
    dump_ready = 1'b1;
    cyc();
    chk("stall31_release", done, 1'b1);
    cyc();
    chk("stall31_pulse", done, 1'b0);
    chk("stall31_q", q.size(), 0);

    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
